// File: rtl/gray_seq_pkg.sv
// Shared encodings and default sizes for the Gray-code sequencing controller.
// State and command values are fixed by the host-visible register map.
package gray_seq_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_DIV_W     = 28;
    localparam int unsigned DEF_DIV_VALUE = (1 << 25) - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_STOP  = 2'b00,
        OP_RUN   = 2'b01,
        OP_STEP  = 2'b10,
        OP_CLEAR = 2'b11
    } cmd_op_e;

endpackage

// File: rtl/gray_seq_ctrl_tick_prescaler.sv
// Programmable tick prescaler: one-cycle tick every (divisor+1) enabled cycles.
// Replaces the old derived slow clock with a clock-enable.
module tick_prescaler
    import gray_seq_pkg::*;
#(
    parameter int unsigned            DIV_W       = DEF_DIV_W,
    parameter logic [DIV_W-1:0]       DEFAULT_DIV = DIV_W'(DEF_DIV_VALUE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_value,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_count;
    logic [DIV_W-1:0] r_div;

    // Compare against the divisor in force this cycle, so a load only affects later ticks.
    assign o_tick = i_enable && (r_count == r_div);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_div   <= DEFAULT_DIV;
        end else begin
            if (i_load) begin
                r_div <= i_load_value;
            end
            if (i_load || i_clear || !i_enable || o_tick) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Command-driven Gray-code counter sequencer (RUN/STOP/STEP/CLEAR) with wrap reporting.
// Binary counter advances on prescaler ticks; count is its Gray encoding.
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEF_WIDTH,
    parameter int unsigned      DIV_W       = DEF_DIV_W,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(DEF_DIV_VALUE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             wrap,
    output logic [1:0]       state
);

    state_e           r_state;
    state_e           w_next_state;
    logic             r_cmd_ready;
    logic             r_busy;
    logic             r_wrap;
    logic [WIDTH-1:0] r_bin;

    cmd_op_e w_op;
    logic    w_accept;
    logic    w_tick;
    logic    w_presc_en;
    logic    w_presc_clr;
    logic    w_clear_bin;
    logic    w_inc;

    assign w_op        = cmd_op_e'(cmd_op);
    assign w_accept    = cmd_valid && r_cmd_ready;
    assign w_presc_en  = (r_state != ST_IDLE);
    assign w_presc_clr = w_accept && (r_state == ST_RUN) &&
                         ((w_op == OP_STOP) || (w_op == OP_CLEAR));
    // CLEAR beats a coincident tick: no increment and therefore no wrap.
    assign w_clear_bin = w_accept && (w_op == OP_CLEAR);
    assign w_inc       = w_tick && !w_clear_bin;

    tick_prescaler #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_presc (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (w_presc_en),
        .i_clear      (w_presc_clr),
        .i_load       (div_load),
        .i_load_value (div_value),
        .o_tick       (w_tick)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_RUN:  w_next_state = ST_RUN;
                        OP_STEP: w_next_state = ST_STEP;
                        default: w_next_state = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    case (w_op)
                        OP_STOP, OP_CLEAR: w_next_state = ST_IDLE;
                        OP_STEP:           w_next_state = ST_STEP;
                        default:           w_next_state = ST_RUN;
                    endcase
                end
            end
            ST_STEP: begin
                if (w_tick) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_busy      <= (w_next_state != ST_IDLE);
            r_cmd_ready <= (w_next_state != ST_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bin  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_inc && (r_bin == '1);
            if (w_clear_bin) begin
                r_bin <= '0;
            end else if (w_inc) begin
                r_bin <= r_bin + WIDTH'(1);
            end
        end
    end

    assign count     = r_bin ^ (r_bin >> 1);
    assign busy      = r_busy;
    assign wrap      = r_wrap;
    assign cmd_ready = r_cmd_ready;
    assign state     = r_state;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed self-checking bench for gray_seq_ctrl.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_gray_seq_ctrl;
    import gray_seq_pkg::*;

    localparam int unsigned     W       = 8;
    localparam int unsigned     DW      = 28;
    localparam logic [DW-1:0]   DEF_DIV = 28'd33554431;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic          div_load;
    logic [DW-1:0] div_value;
    logic [W-1:0]  count;
    logic          busy;
    logic          wrap;
    logic [1:0]    state;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    gray_seq_ctrl #(
        .WIDTH       (W),
        .DIV_W       (DW),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .div_load  (div_load),
        .div_value (div_value),
        .count     (count),
        .busy      (busy),
        .wrap      (wrap),
        .state     (state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_div(input logic [DW-1:0] v);
        div_load  = 1'b1;
        div_value = v;
        step();
        div_load  = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] op);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            checks++;
            $display("FAIL cmd_handshake_timeout cmd_ready=%b expected=1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; div_load = 1'b0; div_value = '0;
        repeat (3) step();
        checks++; if (count !== 8'h00) $display("FAIL por_count got=%h exp=00", count); else passes++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL por_ready got=%b exp=1", cmd_ready); else passes++;
        reset = 1'b1;
        step();
        load_div(28'd3);
        send_cmd(OP_RUN);
        repeat (10) step();
        checks++; if (count !== 8'h03) $display("FAIL prereset_count got=%h exp=03", count); else passes++;
        reset = 1'b0;
        repeat (3) step();
        checks++; if (count !== 8'h00) $display("FAIL reset_count got=%h exp=00", count); else passes++;
        checks++; if (state !== 2'b00) $display("FAIL reset_state got=%b exp=00", state); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", cmd_ready); else passes++;
        checks++; if (wrap !== 1'b0) $display("FAIL reset_wrap got=%b exp=0", wrap); else passes++;
        checks++; if (dut.u_presc.r_div !== DEF_DIV) $display("FAIL reset_div got=%h exp=%h", dut.u_presc.r_div, DEF_DIV); else passes++;
        reset = 1'b1;
        step();
    endtask

    task automatic test_run_div3();
        logic [7:0] exp_g [0:10];
        exp_g = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C, 8'h0D, 8'h0F};
        load_div(28'd3);
        send_cmd(OP_RUN);
        checks++; if (state !== 2'b01) $display("FAIL run_state got=%b exp=01", state); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL run_busy got=%b exp=1", busy); else passes++;
        for (int c = 1; c <= 40; c++) begin
            step();
            checks++;
            if (count !== exp_g[c / 4]) $display("FAIL run_count cyc=%0d got=%h exp=%h", c, count, exp_g[c / 4]);
            else passes++;
        end
        send_cmd(OP_STOP);
        checks++; if (state !== 2'b00) $display("FAIL stop_state got=%b exp=00", state); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL stop_busy got=%b exp=0", busy); else passes++;
        checks++; if (count !== 8'h0F) $display("FAIL stop_count got=%h exp=0F", count); else passes++;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_c [0:3];
        logic       exp_w [0:3];
        exp_c = '{8'h81, 8'h80, 8'h00, 8'h01};
        exp_w = '{1'b0, 1'b0, 1'b1, 1'b0};
        load_div(28'd0);
        send_cmd(OP_CLEAR);
        checks++; if (count !== 8'h00) $display("FAIL idle_clear_count got=%h exp=00", count); else passes++;
        send_cmd(OP_RUN);
        repeat (253) step();
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (count !== exp_c[k]) $display("FAIL wrap_count k=%0d got=%h exp=%h", k, count, exp_c[k]); else passes++;
            checks++; if (wrap !== exp_w[k]) $display("FAIL wrap_pulse k=%0d got=%b exp=%b", k, wrap, exp_w[k]); else passes++;
        end
        send_cmd(OP_STOP);
        checks++; if (count !== 8'h03) $display("FAIL stop_on_tick_count got=%h exp=03", count); else passes++;
        checks++; if (state !== 2'b00) $display("FAIL stop_on_tick_state got=%b exp=00", state); else passes++;
        step();
        checks++; if (count !== 8'h03) $display("FAIL after_stop_count got=%h exp=03", count); else passes++;
    endtask

    task automatic test_step();
        logic [7:0] exp_g [0:2];
        logic [7:0] prev;
        exp_g = '{8'h01, 8'h03, 8'h02};
        prev  = 8'h00;
        load_div(28'd2);
        send_cmd(OP_CLEAR);
        for (int i = 0; i < 3; i++) begin
            send_cmd(OP_STEP);
            checks++; if (state !== 2'b10) $display("FAIL step_state i=%0d got=%b exp=10", i, state); else passes++;
            for (int j = 0; j < 3; j++) begin
                checks++; if (cmd_ready !== 1'b0) $display("FAIL step_ready_low i=%0d j=%0d got=%b exp=0", i, j, cmd_ready); else passes++;
                checks++; if (count !== prev) $display("FAIL step_hold i=%0d j=%0d got=%h exp=%h", i, j, count, prev); else passes++;
                step();
            end
            checks++; if (count !== exp_g[i]) $display("FAIL step_count i=%0d got=%h exp=%h", i, count, exp_g[i]); else passes++;
            checks++; if (state !== 2'b00) $display("FAIL step_done_state i=%0d got=%b exp=00", i, state); else passes++;
            checks++; if (cmd_ready !== 1'b1) $display("FAIL step_done_ready i=%0d got=%b exp=1", i, cmd_ready); else passes++;
            prev = exp_g[i];
        end
    endtask

    task automatic test_clear_on_tick();
        load_div(28'd3);
        send_cmd(OP_RUN);
        repeat (4) step();
        checks++; if (count !== 8'h06) $display("FAIL pre_clear_count got=%h exp=06", count); else passes++;
        repeat (3) step();
        cmd_valid = 1'b1;
        cmd_op    = OP_CLEAR;
        step();
        cmd_valid = 1'b0;
        checks++; if (count !== 8'h00) $display("FAIL clear_tick_count got=%h exp=00", count); else passes++;
        checks++; if (wrap !== 1'b0) $display("FAIL clear_tick_wrap got=%b exp=0", wrap); else passes++;
        checks++; if (state !== 2'b00) $display("FAIL clear_tick_state got=%b exp=00", state); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL clear_tick_busy got=%b exp=0", busy); else passes++;
        step();
        checks++; if (count !== 8'h00) $display("FAIL post_clear_count got=%h exp=00", count); else passes++;
    endtask

    task automatic test_stop_restart();
        send_cmd(OP_RUN);
        repeat (5) step();
        send_cmd(OP_STOP);
        checks++; if (count !== 8'h01) $display("FAIL midstop_count got=%h exp=01", count); else passes++;
        checks++; if (state !== 2'b00) $display("FAIL midstop_state got=%b exp=00", state); else passes++;
        repeat (2) step();
        send_cmd(OP_RUN);
        repeat (3) step();
        checks++; if (count !== 8'h01) $display("FAIL restart_early got=%h exp=01", count); else passes++;
        step();
        checks++; if (count !== 8'h03) $display("FAIL restart_inc got=%h exp=03", count); else passes++;
        send_cmd(OP_STOP);
    endtask

    task automatic test_load_during_step();
        send_cmd(OP_STEP);
        step();
        load_div(28'd5);
        for (int c = 1; c <= 5; c++) begin
            step();
            checks++; if (count !== 8'h03) $display("FAIL ldstep_hold c=%0d got=%h exp=03", c, count); else passes++;
            checks++; if (state !== 2'b10) $display("FAIL ldstep_state c=%0d got=%b exp=10", c, state); else passes++;
        end
        step();
        checks++; if (count !== 8'h02) $display("FAIL ldstep_count got=%h exp=02", count); else passes++;
        checks++; if (state !== 2'b00) $display("FAIL ldstep_done_state got=%b exp=00", state); else passes++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL ldstep_done_ready got=%b exp=1", cmd_ready); else passes++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout sim time exceeded limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run_div3();
        test_wrap();
        test_step();
        test_clear_on_tick();
        test_stop_restart();
        test_load_during_step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
